fetch_ifid_stage: RTL and testbench
===================================

Name: fetch_ifid_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit WISC-SP13 five-stage pipeline.
- Holds the PC and drives the stalling instruction memory.
- Obeys the PCwriteEn/IFIDwriteEn stall controls from the hazard detection unit.
- Applies branch/jump redirects (flush) from the later stages.
- Freezes fetch after a HALT is captured.
- Feeds the decode stage, whose register specifiers the hazard unit compares.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, bubble instruction (opcode 00001) inserted into IF/ID

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
PCwriteEn  input  1  from hazard unit; 0 = hold PC
IFIDwriteEn  input  1  from hazard unit; 0 = hold IF/ID contents
flush  input  1  taken branch/jump; squash IF/ID and redirect
redirectPC  input  16  target PC, valid when flush=1
imemAddr  output  16  instruction memory address
imemRd  output  1  instruction memory read request
imemData  input  16  instruction returned by memory
imemStall  input  1  memory not done this cycle; imemData invalid
ifidInstr  output  16  IF/ID instruction
ifidPCplus2  output  16  IF/ID PC+2 (for branch/JAL)
ifidValid  output  1  IF/ID holds a real instruction
fetchStall  output  1  fetch waiting on memory (imemRd & imemStall)
halted  output  1  fetch frozen on HALT

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC, state=FETCH, pendValid=0, pendPC=0.
  - ifidInstr=NOP_INSTR, ifidPCplus2=0, ifidValid=0, halted=0.
- imemAddr=PC. imemRd=(state!=HALTED).
- States:
  - FETCH: request at PC.
  - WAIT_MEM: memory busy; address must stay stable.
  - HALTED: no requests.
- done = imemRd & ~imemStall. The fetch completes in the same cycle; done => memory returned data that cycle.
- FETCH:
  - imemStall=1 -> WAIT_MEM.
  - flush -> PC<=redirectPC; stay FETCH.
  - done & PCwriteEn & IFIDwriteEn & imemData[15:11]==00000 -> HALTED, PC held.
  - done & PCwriteEn otherwise -> PC<=PC+2, modulo 2^16 (16'hFFFE -> 16'h0000).
- WAIT_MEM:
  - PC and imemAddr held.
  - flush -> pendPC<=redirectPC, pendValid<=1. A later flush overwrites pendPC.
  - done:
    - pendValid (or flush this cycle) -> discard data, PC<=pendPC or redirectPC, clear pendValid, go to FETCH.
    - otherwise behave as a FETCH completion, including the HALT check.
- HALTED:
  - PC held, no memory traffic.
  - flush -> PC<=redirectPC, state FETCH, halted=0. This case is a speculatively fetched HALT.
- IF/ID update, evaluated in priority order:
  1. flush -> ifidInstr=NOP_INSTR, ifidValid=0. Overrides IFIDwriteEn=0.
  2. IFIDwriteEn=0 -> hold all three fields.
  3. done & no pending/current redirect -> ifidInstr=imemData, ifidPCplus2=PC+2, ifidValid=1.
  4. otherwise -> bubble (NOP_INSTR, valid=0).
- PCwriteEn=0 with a completed fetch: data dropped and the same PC refetched later. No duplicate entry in IF/ID is required to be prevented; the hazard unit drives both enables equal.
- HALT seen with IFIDwriteEn=0 or flush: not captured; no HALTED transition.
- halted=(state==HALTED), registered. fetchStall combinational.

Decomposition:
- Shared constants header (wisc_defs), used by decode/control:
  - OP_HALT=5'b00000, OP_NOP=5'b00001, NOP_INSTR.
  - Fetch state encoding (FETCH=2'd0, WAIT_MEM=2'd1, HALTED=2'd2).
- One sub-module, ifid_reg:
  - 33-bit register, async reset to {NOP_INSTR,16'h0,1'b0}.
  - Write-enable and synchronous flush inputs.
- PC register, pending-redirect register and FSM in the top.

Test Plan:
- Reset, imemStall=0, memory returns 16'h4000.. at 0,2,4: PC 0->2->4->6; IF/ID shows instr from PC 0 with ifidPCplus2=2 one cycle after reset release, ifidValid=1.
- PCwriteEn=IFIDwriteEn=0 for 2 cycles at PC=4: PC stays 4, IF/ID holds instr@2, then resumes with instr@4.
- imemStall=1 for 3 cycles at PC=6, flush with redirectPC=16'h0040 in 2nd cycle: IF/ID NOP/valid=0, returned data discarded, next PC=0x0040, fetchStall high 3 cycles.
- Fetch 16'h0000 at PC=8: ifidInstr=0000, valid=1, PC stays 8, halted=1, imemRd=0. Then flush to 0x0010: halted=0, fetch resumes at 0x0010.
- HALT fetched while flush=1: IF/ID NOP, PC=redirectPC, halted stays 0.
- PC=16'hFFFE, no stall: next PC=16'h0000, ifidPCplus2=16'h0000. rst asserted mid-WAIT_MEM: outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_ifid_stage_pkg.sv
// Shared WISC-SP13 fetch/decode constants, fetch state encoding and IF/ID word layout.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fetch_ifid_stage_pkg;

    localparam logic [4:0]  OP_HALT  = 5'b00000;
    localparam logic [4:0]  OP_NOP   = 5'b00001;
    localparam logic [15:0] NOP_WORD = {OP_NOP, 11'h000};

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_MEM = 2'd1,
        HALTED   = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pcPlus2;
        logic        valid;
    } ifid_t;

    function automatic logic isHalt(input logic [15:0] instr);
        return instr[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_ifid_stage_ifid.sv
// IF/ID pipeline register: 33-bit word with write enable and synchronous flush.
// Latency: 1 cycle from d to q.
// Backpressure: writeEn=0 holds the word; flush squashes to a bubble regardless of writeEn.
module ifid_reg
    import fetch_ifid_stage_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_WORD
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  writeEn,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= {NOP_INSTR, 16'h0000, 1'b0};
        end else if (flush) begin
            // PC+2 of a squashed slot is meaningless, so it is simply left alone
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (writeEn) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch (PC, stalling imem handshake, redirect, HALT freeze) feeding the IF/ID register.
// Latency: instruction appears in IF/ID the cycle after memory completes it.
// Backpressure: PCwriteEn/IFIDwriteEn hold PC and IF/ID; imemStall holds the request address.
module fetch_ifid_stage
    import fetch_ifid_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCwriteEn,
    input  logic        IFIDwriteEn,
    input  logic        flush,
    input  logic [15:0] redirectPC,
    output logic [15:0] imemAddr,
    output logic        imemRd,
    input  logic [15:0] imemData,
    input  logic        imemStall,
    output logic [15:0] ifidInstr,
    output logic [15:0] ifidPCplus2,
    output logic        ifidValid,
    output logic        fetchStall,
    output logic        halted
);

    fetch_state_t state, stateNext;
    logic [15:0]  pc, pcNext, pcPlus2;
    logic [15:0]  pendPC, pendPCNext;
    logic         pendValid, pendValidNext;
    logic         done, capture;
    ifid_t        ifidD, ifidQ;

    assign pcPlus2    = pc + 16'd2;
    assign imemAddr   = pc;
    assign imemRd     = (state != HALTED);
    assign done       = imemRd & ~imemStall;
    assign fetchStall = imemRd & imemStall;
    assign halted     = (state == HALTED);
    // Data returned while a redirect is owed belongs to the squashed path
    assign capture    = done & ~flush & ~pendValid;

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        pendPCNext    = pendPC;
        pendValidNext = pendValid;
        case (state)
            FETCH, WAIT_MEM: begin
                if (imemStall) begin
                    // Address must stay stable while memory is busy, so park the redirect
                    stateNext = WAIT_MEM;
                    if (flush) begin
                        pendPCNext    = redirectPC;
                        pendValidNext = 1'b1;
                    end
                end else begin
                    stateNext     = FETCH;
                    pendValidNext = 1'b0;
                    if (flush) begin
                        pcNext = redirectPC;
                    end else if (pendValid) begin
                        pcNext = pendPC;
                    end else if (PCwriteEn && IFIDwriteEn && isHalt(imemData)) begin
                        stateNext = HALTED;
                    end else if (PCwriteEn) begin
                        pcNext = pcPlus2;
                    end
                end
            end
            HALTED: begin
                // A HALT fetched down a mispredicted path is undone by the redirect
                if (flush) begin
                    pcNext    = redirectPC;
                    stateNext = FETCH;
                end
            end
            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            pendPC    <= 16'h0000;
            pendValid <= 1'b0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            pendPC    <= pendPCNext;
            pendValid <= pendValidNext;
        end
    end

    always_comb begin
        ifidD.instr   = capture ? imemData : NOP_INSTR;
        ifidD.pcPlus2 = pcPlus2;
        ifidD.valid   = capture;
    end

    ifid_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid (
        .clk    (clk),
        .rst    (rst),
        .writeEn(IFIDwriteEn),
        .flush  (flush),
        .d      (ifidD),
        .q      (ifidQ)
    );

    assign ifidInstr   = ifidQ.instr;
    assign ifidPCplus2 = ifidQ.pcPlus2;
    assign ifidValid   = ifidQ.valid;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Self-checking bench for fetch_ifid_stage: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level fetch model.
module tb_fetch_ifid_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCwriteEn = 1'b1, IFIDwriteEn = 1'b1, flush = 1'b0, imemStall = 1'b0;
    logic [15:0] redirectPC = 16'h0000, imemData = 16'h0000;
    logic [15:0] imemAddr, ifidInstr, ifidPCplus2;
    logic        imemRd, ifidValid, fetchStall, halted;

    int checks = 0;
    int errors = 0;
    int stallCnt = 0;

    fetch_ifid_stage dut (
        .clk        (clk),
        .rst        (rst),
        .PCwriteEn  (PCwriteEn),
        .IFIDwriteEn(IFIDwriteEn),
        .flush      (flush),
        .redirectPC (redirectPC),
        .imemAddr   (imemAddr),
        .imemRd     (imemRd),
        .imemData   (imemData),
        .imemStall  (imemStall),
        .ifidInstr  (ifidInstr),
        .ifidPCplus2(ifidPCplus2),
        .ifidValid  (ifidValid),
        .fetchStall (fetchStall),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem(input logic [15:0] a);
        return 16'h4000 | a;
    endfunction

    // Model: a fetch is either outstanding or frozen; a redirect seen while the
    // memory is busy is remembered and applied when that access finishes.
    logic [15:0] mPc, mPendPC, mInstr, mPc2;
    bit          mHalted, mPend, mValid, doneM;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPc = 16'h0000; mPendPC = 16'h0000; mPend = 0; mHalted = 0;
            mInstr = NOP; mPc2 = 16'h0000; mValid = 0;
        end else begin
            doneM = !mHalted && !imemStall;
            if (flush) begin
                mInstr = NOP; mValid = 0;
            end else if (IFIDwriteEn) begin
                if (doneM && !mPend) begin
                    mInstr = imemData; mPc2 = mPc + 16'd2; mValid = 1;
                end else begin
                    mInstr = NOP; mValid = 0;
                end
            end
            if (mHalted) begin
                if (flush) begin mPc = redirectPC; mHalted = 0; end
            end else if (!doneM) begin
                if (flush) begin mPend = 1; mPendPC = redirectPC; end
            end else if (flush || mPend) begin
                mPc = flush ? redirectPC : mPendPC;
                mPend = 0;
            end else if (PCwriteEn && IFIDwriteEn && imemData[15:11] == 5'b00000) begin
                mHalted = 1;
            end else if (PCwriteEn) begin
                mPc = mPc + 16'd2;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fetchStall === 1'b1) stallCnt++;
            chk("imemAddr", imemAddr, mPc);
            chk("imemRd", {15'h0, imemRd}, {15'h0, !mHalted});
            chk("fetchStall", {15'h0, fetchStall}, {15'h0, !mHalted && imemStall});
            chk("halted", {15'h0, halted}, {15'h0, mHalted});
            chk("ifidValid", {15'h0, ifidValid}, {15'h0, mValid});
            chk("ifidInstr", ifidInstr, mInstr);
            if (mValid) chk("ifidPCplus2", ifidPCplus2, mPc2);
        end
    end

    task automatic cyc(input logic pw, input logic iw, input logic fl, input logic [15:0] rp,
                       input logic st, input logic [15:0] dat);
        PCwriteEn = pw; IFIDwriteEn = iw; flush = fl; redirectPC = rp;
        imemStall = st; imemData = dat;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        pw, iw;
        logic [15:0] d;
        #1 rst = 1'b1;
        #1;
        chk("reset imemAddr", imemAddr, 16'h0000);
        chk("reset ifidInstr", ifidInstr, NOP);
        chk("reset ifidPCplus2", ifidPCplus2, 16'h0000);
        chk("reset ifidValid", {15'h0, ifidValid}, 16'h0);
        chk("reset halted", {15'h0, halted}, 16'h0);
        chk("reset imemRd", {15'h0, imemRd}, 16'h1);
        @(posedge clk); #1 rst = 1'b0;

        // Sequential fetch 0 -> 2 -> 4
        cyc(1, 1, 0, 16'h0, 0, mem(mPc));
        chk("seq addr2", imemAddr, 16'h0002);
        chk("seq instr0", ifidInstr, 16'h4000);
        chk("seq pc2", ifidPCplus2, 16'h0002);
        chk("seq valid", {15'h0, ifidValid}, 16'h1);
        cyc(1, 1, 0, 16'h0, 0, mem(mPc));
        chk("seq addr4", imemAddr, 16'h0004);

        // Hazard stall for two cycles at PC 4
        cyc(0, 0, 0, 16'h0, 0, mem(mPc));
        cyc(0, 0, 0, 16'h0, 0, mem(mPc));
        chk("hold addr", imemAddr, 16'h0004);
        chk("hold instr", ifidInstr, 16'h4002);
        cyc(1, 1, 0, 16'h0, 0, mem(mPc));
        chk("resume instr", ifidInstr, 16'h4004);
        chk("resume addr", imemAddr, 16'h0006);

        // Memory stall with a redirect arriving mid-wait
        stallCnt = 0;
        cyc(1, 1, 0, 16'h0, 1, 16'hBEEF);
        chk("stall addr held", imemAddr, 16'h0006);
        cyc(1, 1, 1, 16'h0040, 1, 16'hBEEF);
        chk("stall flush valid", {15'h0, ifidValid}, 16'h0);
        cyc(1, 1, 0, 16'h0, 1, 16'hBEEF);
        cyc(1, 1, 0, 16'h0, 0, 16'h1234);
        chk("redir addr", imemAddr, 16'h0040);
        chk("redir instr", ifidInstr, NOP);
        chk("redir valid", {15'h0, ifidValid}, 16'h0);
        chk("stall cycles", stallCnt[15:0], 16'd3);

        // HALT capture and release
        cyc(1, 1, 1, 16'h0008, 0, mem(mPc));
        cyc(1, 1, 0, 16'h0, 0, 16'h0000);
        chk("halt instr", ifidInstr, 16'h0000);
        chk("halt valid", {15'h0, ifidValid}, 16'h1);
        chk("halt addr", imemAddr, 16'h0008);
        chk("halt flag", {15'h0, halted}, 16'h1);
        chk("halt imemRd", {15'h0, imemRd}, 16'h0);
        cyc(1, 1, 0, 16'h0, 0, mem(mPc));
        chk("halt stays", {15'h0, halted}, 16'h1);
        cyc(1, 1, 1, 16'h0010, 0, mem(mPc));
        chk("unhalt flag", {15'h0, halted}, 16'h0);
        chk("unhalt addr", imemAddr, 16'h0010);
        cyc(1, 1, 0, 16'h0, 0, mem(mPc));
        chk("unhalt instr", ifidInstr, 16'h4010);
        chk("unhalt pc2", ifidPCplus2, 16'h0012);

        // HALT fetched under a flush is not captured
        cyc(1, 1, 1, 16'h0030, 0, 16'h0000);
        chk("spec halt instr", ifidInstr, NOP);
        chk("spec halt addr", imemAddr, 16'h0030);
        chk("spec halt flag", {15'h0, halted}, 16'h0);

        // PC wraparound
        cyc(1, 1, 1, 16'hFFFE, 0, mem(mPc));
        cyc(1, 1, 0, 16'h0, 0, mem(mPc));
        chk("wrap addr", imemAddr, 16'h0000);
        chk("wrap pc2", ifidPCplus2, 16'h0000);
        chk("wrap instr", ifidInstr, 16'hFFFE);

        // Reset asserted while waiting on memory
        cyc(1, 1, 0, 16'h0, 0, mem(mPc));
        cyc(1, 1, 0, 16'h0, 1, 16'hBEEF);
        chk("pre-reset addr", imemAddr, 16'h0002);
        rst = 1'b1;
        imemStall = 1'b0;
        #1;
        chk("midrst addr", imemAddr, 16'h0000);
        chk("midrst instr", ifidInstr, NOP);
        chk("midrst valid", {15'h0, ifidValid}, 16'h0);
        chk("midrst halted", {15'h0, halted}, 16'h0);
        chk("midrst imemRd", {15'h0, imemRd}, 16'h1);
        @(posedge clk); #1 rst = 1'b0;

        // Randomized traffic against the model
        repeat (3000) begin
            pw = ($urandom_range(0, 9) != 0);
            iw = pw ^ ($urandom_range(0, 11) == 0);
            d = 16'($urandom);
            if ($urandom_range(0, 7) == 0) d[15:11] = 5'b00000;
            cyc(pw, iw, ($urandom_range(0, 9) == 0), 16'($urandom) & 16'hFFFE,
                ($urandom_range(0, 9) < 3), d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
